// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the instruction queue between fetch and decode.
package inst_queue_pkg;

   // Default number of queue entries.
   localparam int IQ_DEPTH = 8;

   // One fetched instruction as held in the queue.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
   } fetch_entry_t;

endpackage : inst_queue_pkg

// File: rtl/inst_queue.sv
// Show-ahead circular instruction queue between fetch and decode.
// DEPTH must be a power of two and at least 2. Pointers carry one extra wrap
// bit, so full means equal indices with different wrap bits and empty means
// fully equal pointers. The occupancy counter tracks the same condition, and
// queue_full / out_valid come straight from it. Storage is never reset; only
// the pointers and the counter are.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_instruction,
   output logic             queue_full,
   output logic             out_valid,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_instruction,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [IDX_W:0]   rptr_q;
   logic [IDX_W:0]   rptr_d;
   logic [IDX_W:0]   wptr_q;
   logic [IDX_W:0]   wptr_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     wr_entry_s;
   fetch_entry_t     head_s;

   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;

   // Status flags, handshakes and the next pointer/count values.
   always_comb begin
      full_s     = (count_q == CNT_W'(DEPTH));
      empty_s    = (count_q == {CNT_W{1'b0}});
      // A push while full is dropped even if a pop frees a slot this cycle,
      // so the full flag never depends on out_ready.
      push_s     = in_valid && !full_s && !flush;
      pop_s      = !empty_s && out_ready && !flush;
      wr_entry_s = '{pc: in_pc, instruction: in_instruction};
      head_s     = mem_q[rptr_q[IDX_W-1:0]];
      rptr_d     = rptr_q;
      wptr_d     = wptr_q;
      count_d    = count_q;

      if (flush) begin
         rptr_d  = {(IDX_W + 1){1'b0}};
         wptr_d  = {(IDX_W + 1){1'b0}};
         count_d = {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wptr_d = wptr_q + {{IDX_W{1'b0}}, 1'b1};
         end else begin
            wptr_d = wptr_q;
         end
         if (pop_s) begin
            rptr_d = rptr_q + {{IDX_W{1'b0}}, 1'b1};
         end else begin
            rptr_d = rptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W - 1){1'b0}}, 1'b1};
            default: count_d = count_q;
         endcase
      end
   end

   // Control state: pointers and occupancy, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rptr_q  <= {(IDX_W + 1){1'b0}};
         wptr_q  <= {(IDX_W + 1){1'b0}};
         count_q <= {CNT_W{1'b0}};
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage: written on an accepted push, intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wptr_q[IDX_W-1:0]] <= wr_entry_s;
      end
   end

   // Show-ahead head outputs, forced to zero while the queue is empty.
   always_comb begin
      queue_full      = full_s;
      out_valid       = !empty_s;
      count           = count_q;
      out_pc          = 32'h0000_0000;
      out_instruction = 32'h0000_0000;
      if (!empty_s) begin
         out_pc          = head_s.pc;
         out_instruction = head_s.instruction;
      end else begin
         out_pc          = 32'h0000_0000;
         out_instruction = 32'h0000_0000;
      end
   end

endmodule : inst_queue
